// File: rtl/xadc_drp_reader.sv
// Reads one XADC DRP channel after every end-of-conversion and emits a
// boxcar average of 2^AVG_LOG2 readings; a missing drdy sets a sticky error.
module xadc_drp_reader #(
    parameter logic [6:0] CHANNEL_ADDR = 7'h1E,
    parameter int         AVG_LOG2     = 2,
    parameter int         TIMEOUT      = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] dout,
    output logic        den,
    output logic [6:0]  daddr,
    output logic [7:0]  sample,
    output logic        sample_valid,
    output logic        timeout_err
);

    localparam int         ACC_W    = 12 + AVG_LOG2;
    localparam int         CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_toCnt;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_rdCnt;
    logic [7:0]       r_sample;
    logic             r_valid;
    logic             r_err;

    logic             w_capture;
    logic             w_timeout;
    logic             w_lastRead;
    logic [7:0]       w_toNext;
    logic [ACC_W-1:0] w_sum;
    logic [11:0]      w_mean;
    logic             w_unused;

    assign daddr        = CHANNEL_ADDR;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign timeout_err  = r_err;

    // drdy takes priority over a timeout landing on the same edge
    assign w_toNext   = r_toCnt + 8'd1;
    assign w_capture  = (r_state == WAIT) && drdy;
    assign w_timeout  = (r_state == WAIT) && !drdy && (w_toNext == TO_LIMIT);
    assign w_sum      = r_acc + ACC_W'(dout[15:4]);
    assign w_mean     = 12'(w_sum >> AVG_LOG2);
    assign w_lastRead = (AVG_LOG2 == 0) || (r_rdCnt == '1);
    assign w_unused   = ^{dout[3:0], w_mean[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        den         = 1'b0;
        case (r_state)
            IDLE: begin
                if (eoc) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                den         = 1'b1;
                w_nextState = WAIT;
            end
            WAIT: begin
                if (drdy || (w_toNext == TO_LIMIT)) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toCnt  <= 8'd0;
            r_acc    <= '0;
            r_rdCnt  <= '0;
            r_sample <= 8'h00;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == REQ) begin
                r_toCnt <= 8'd0;
            end else if ((r_state == WAIT) && !drdy) begin
                r_toCnt <= w_toNext;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // the completing reading folds straight into the published mean
            if (w_capture) begin
                if (w_lastRead) begin
                    r_sample <= w_mean[11:4];
                    r_valid  <= 1'b1;
                    r_acc    <= '0;
                    r_rdCnt  <= '0;
                end else begin
                    r_acc   <= w_sum;
                    r_rdCnt <= r_rdCnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/xadc_drp_reader.md
XADC_DRP_READER -- requirements
Module: xadc_drp_reader

Interface
REQ-001 Parameter CHANNEL_ADDR, default 7'h1E: DRP address read on every conversion.
REQ-002 Parameter AVG_LOG2, default 2: number of readings averaged per output sample is 2^AVG_LOG2; legal range 0..4.
REQ-003 Parameter TIMEOUT, default 63: maximum cycles waited for drdy after den; legal range 1..255.
REQ-004 clk  in  1  single clock; XADC dclk and all logic run on it.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 eoc  in  1  XADC end-of-conversion flag.
REQ-007 drdy  in  1  XADC DRP data-ready.
REQ-008 dout  in  16  XADC DRP data out; conversion result in dout[15:4].
REQ-009 den  out  1  DRP enable to XADC, one-cycle pulse per read.
REQ-010 daddr  out  7  DRP address, constant CHANNEL_ADDR.
REQ-011 sample  out  8  averaged result, upper 8 bits of the 12-bit mean; held between updates.
REQ-012 sample_valid  out  1  one-cycle pulse when sample updates.
REQ-013 timeout_err  out  1  sticky flag: a read timed out since reset.

Function
REQ-014 FSM states shall be IDLE, REQ, WAIT; all transitions on rising clk.
REQ-015 IDLE: eoc=1 sampled -> REQ; otherwise stay.
REQ-016 REQ: den=1 for exactly this one cycle; next state WAIT, timeout counter cleared to 0.
REQ-017 WAIT: drdy=1 -> capture dout[15:4] into the accumulator, go IDLE; else increment the counter, and if counter reaches TIMEOUT, go IDLE, set timeout_err, discard nothing already accumulated.
REQ-018 den shall be 0 in every state except REQ; daddr shall equal CHANNEL_ADDR at all times, including reset.
REQ-019 eoc while in REQ or WAIT shall be ignored (not queued).
REQ-020 drdy outside WAIT shall be ignored.
REQ-021 Accumulator width shall be 12+AVG_LOG2 bits, unsigned, no overflow possible; a read counter of AVG_LOG2 bits counts captured readings.
REQ-022 On the capture that completes 2^AVG_LOG2 readings: sample <= (accumulator_sum >> AVG_LOG2)[11:4] (truncation, no rounding), sample_valid=1 in the next cycle, accumulator and read counter cleared in the same update.
REQ-023 With AVG_LOG2=0 every capture shall produce sample = dout[15:8] and a sample_valid pulse.
REQ-024 Latency: eoc high at edge N -> den high in cycle N+1; drdy high at edge M -> sample_valid high in cycle M+1 when the average completes.
REQ-025 Read counter wraps to 0 after 2^AVG_LOG2 readings; a timed-out read shall not increment it.
REQ-026 drdy and timeout reaching TIMEOUT on the same cycle: drdy wins, data captured, timeout_err unchanged.

Reset
REQ-027 rst=1 shall asynchronously force: state IDLE, den=0, sample=8'h00, sample_valid=0, timeout_err=0, accumulator=0, read counter=0, timeout counter=0.
REQ-028 rst asserted mid-read (REQ or WAIT) shall abort the read; a drdy arriving after rst release while in IDLE shall be ignored.
REQ-029 Outputs leave reset state only on the first clk edge after rst deasserts.

Verification
REQ-030 AVG_LOG2=2; four eoc/drdy reads with dout=16'h8000,16'h8010,16'h8020,16'h8030 -> exactly one sample_valid, sample=8'h80, sum 12'h801+12'h802+12'h803+12'h800 mean truncated.
REQ-031 AVG_LOG2=0; eoc then drdy two cycles after den with dout=16'hA5F0 -> den one cycle, sample=8'hA5 with sample_valid one cycle after drdy.
REQ-032 eoc, drdy never asserted, TIMEOUT=63 -> den once, return to IDLE 63 cycles after WAIT entry, timeout_err=1 and held; next eoc starts a new read normally.
REQ-033 eoc pulsed three times during WAIT -> no additional den; single capture on drdy.
REQ-034 rst asserted in WAIT, then drdy pulse after release -> sample=8'h00, no sample_valid, accumulator unchanged at 0.
REQ-035 drdy on the exact cycle counter hits TIMEOUT -> data captured, timeout_err stays 0.
